// File: rtl/dma_2d_pkg.sv
// Shared definitions for the 2D DMA read and write masters: FSM states and
// AXI burst constants.
package dma_2d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_ARQ,
        ST_RDAT,
        ST_DONE
    } dma_state_t;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam int unsigned AXI_4KB        = 4096;
    localparam int unsigned BEAT_BYTES     = 4;

endpackage

// File: rtl/dma_2d_burst_planner.sv
// Combinational burst sizing: the shortest of the rest of the row, the
// maximum burst length and the room left before the next 4 KB page.
module dma_2d_burst_planner
    import dma_2d_pkg::*;
#(
    parameter int C_M_AXI_BURST_LEN = 16
) (
    input  logic [11:0] cur_addr,
    input  logic [31:0] row_left,
    output logic [8:0]  len
);

    logic [12:0] page_room;
    logic [10:0] page_beats;
    logic [10:0] cap;

    always_comb begin
        // cur_addr is only the in-page offset; the upper address bits never matter here
        page_room  = 13'(AXI_4KB) - {1'b0, cur_addr};
        page_beats = 11'(page_room / 13'(BEAT_BYTES));
        cap        = (page_beats < 11'(C_M_AXI_BURST_LEN)) ? page_beats : 11'(C_M_AXI_BURST_LEN);
        if ({21'd0, cap} > row_left) begin
            len = row_left[8:0];
        end else begin
            len = cap[8:0];
        end
    end

endmodule

// File: rtl/dma_2d_read_master.sv
// AXI4 read master that walks a strided 2D region, one INCR burst in flight,
// and pushes every returned beat into the DMA FIFO.
module dma_2d_read_master
    import dma_2d_pkg::*;
#(
    parameter int C_M_AXI_BURST_LEN   = 16,
    parameter int C_M_AXI_ADDR_WIDTH  = 32,
    parameter int C_M_AXI_DATA_WIDTH  = 32,
    parameter int C_FIFO_SPACE_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
    input  logic [31:0]                   i_img_width,
    input  logic [31:0]                   i_img_height,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_img_stride,
    input  logic [C_FIFO_SPACE_WIDTH-1:0] i_fifo_space,
    output logic                          o_fifo_wr_en,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_fifo_wr_data,
    output logic                          o_busy,
    output logic                          o_read_done,
    output logic                          o_error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready
);

    dma_state_t state, state_nxt;

    logic [C_M_AXI_ADDR_WIDTH-1:0] row_base;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [C_M_AXI_ADDR_WIDTH-1:0] stride;
    logic [31:0]                   width;
    logic [31:0]                   row_left;
    logic [31:0]                   rows_left;
    logic [8:0]                    len_q;
    logic [7:0]                    beat_cnt;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]                    arlen_q;
    logic                          error_q;

    logic [8:0] plan_len;
    logic       start_ok;
    logic       zero_dim;
    logic       fifo_ok;
    logic       beat;
    logic       cnt_final;
    logic       last_beat;
    logic       row_end;
    logic       img_end;
    logic [C_M_AXI_ADDR_WIDTH-1:0] burst_bytes;
    logic [C_M_AXI_ADDR_WIDTH-1:0] next_row;

    dma_2d_burst_planner #(
        .C_M_AXI_BURST_LEN(C_M_AXI_BURST_LEN)
    ) u_planner (
        .cur_addr(cur_addr[11:0]),
        .row_left(row_left),
        .len     (plan_len)
    );

    assign start_ok    = (state == ST_IDLE) && i_start;
    assign zero_dim    = (i_img_width == 32'd0) || (i_img_height == 32'd0);
    assign fifo_ok     = 32'(i_fifo_space) >= 32'(plan_len);
    assign beat        = m_axi_rvalid && m_axi_rready;
    assign cnt_final   = ({1'b0, beat_cnt} == (len_q - 9'd1));
    // The burst is closed by our own count; rlast is only cross-checked
    assign last_beat   = beat && cnt_final;
    assign row_end     = (row_left == 32'(len_q));
    assign img_end     = row_end && (rows_left == 32'd1);
    assign burst_bytes = C_M_AXI_ADDR_WIDTH'(len_q) * C_M_AXI_ADDR_WIDTH'(BEAT_BYTES);
    assign next_row    = row_base + stride;

    always_comb begin
        state_nxt     = state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        o_busy        = 1'b1;
        o_read_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_nxt = zero_dim ? ST_DONE : ST_PLAN;
                end
            end
            ST_PLAN: begin
                if (fifo_ok) begin
                    state_nxt = ST_ARQ;
                end
            end
            ST_ARQ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_nxt = ST_RDAT;
                end
            end
            ST_RDAT: begin
                m_axi_rready = 1'b1;
                if (last_beat) begin
                    state_nxt = img_end ? ST_DONE : ST_PLAN;
                end
            end
            ST_DONE: begin
                o_read_done = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            araddr_q <= '0;
            arlen_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            // AR fields are frozen once planned so they stay stable until arready
            if (state == ST_PLAN && fifo_ok) begin
                araddr_q <= cur_addr;
                arlen_q  <= 8'(plan_len - 9'd1);
            end
            if (start_ok) begin
                error_q <= 1'b0;
            end else if (beat && ((m_axi_rresp != 2'b00) || (m_axi_rlast != cnt_final))) begin
                error_q <= 1'b1;
            end
        end
    end

    // Walk state: only meaningful after a start, so it carries no reset
    always_ff @(posedge clk) begin
        if (start_ok) begin
            row_base  <= i_src_addr;
            cur_addr  <= i_src_addr;
            stride    <= i_img_stride;
            width     <= i_img_width;
            row_left  <= i_img_width;
            rows_left <= i_img_height;
        end
        if (state == ST_PLAN && fifo_ok) begin
            len_q <= plan_len;
        end
        if (state == ST_ARQ) begin
            beat_cnt <= 8'd0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
        if (last_beat) begin
            if (row_end) begin
                row_base  <= next_row;
                cur_addr  <= next_row;
                row_left  <= width;
                rows_left <= rows_left - 32'd1;
            end else begin
                cur_addr <= cur_addr + burst_bytes;
                row_left <= row_left - 32'(len_q);
            end
        end
    end

    assign o_fifo_wr_en   = beat;
    assign o_fifo_wr_data = m_axi_rdata;
    assign o_error        = error_q;
    assign m_axi_araddr   = araddr_q;
    assign m_axi_arlen    = arlen_q;
    assign m_axi_arsize   = AXI_SIZE_4B;
    assign m_axi_arburst  = AXI_BURST_INCR;

endmodule

// File: tb/tb_dma_2d_read_master.sv
// Randomised bench for dma_2d_read_master: an AXI read slave with random
// handshake gaps plus a plain-arithmetic model of the expected bursts.
module tb_dma_2d_read_master;

    localparam int BL    = 16;
    localparam int LIMIT = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [31:0] i_src_addr, i_img_width, i_img_height, i_img_stride;
    logic [15:0] i_fifo_space;
    logic        o_fifo_wr_en;
    logic [31:0] o_fifo_wr_data;
    logic        o_busy, o_read_done, o_error;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    dma_2d_read_master #(
        .C_M_AXI_BURST_LEN(BL), .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32), .C_FIFO_SPACE_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_src_addr(i_src_addr),
        .i_img_width(i_img_width), .i_img_height(i_img_height), .i_img_stride(i_img_stride),
        .i_fifo_space(i_fifo_space), .o_fifo_wr_en(o_fifo_wr_en), .o_fifo_wr_data(o_fifo_wr_data),
        .o_busy(o_busy), .o_read_done(o_read_done), .o_error(o_error),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_ar_addr[$];
    int          exp_ar_len[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_ar_addr[$];
    int          got_ar_len[$];
    logic [31:0] got_data[$];

    logic [31:0] sl_addr[$];
    int          sl_len[$];
    int          beat_i = 0;
    int          beat_total = 0;
    int          err_beat = -1;
    int          ar_pct = 60;
    int          rv_pct = 70;
    bit          corrupt_last = 1'b0;
    bit          spurious = 1'b0;

    int   ar_base, d_base;
    logic busy1, arv1, err1, busy_after, done_after;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // Slave: drives at the falling edge, so each handshake it records is the
    // one the DUT sees at the following rising edge.
    initial begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                sl_addr.delete(); sl_len.delete(); beat_i = 0;
                m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
            end else begin
                if (sl_addr.size() > 0 && $urandom_range(99) < rv_pct) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = mem_word(sl_addr[0] + 32'(4 * beat_i));
                    m_axi_rlast  = (beat_i == sl_len[0] - 1) ^ corrupt_last;
                    m_axi_rresp  = (beat_total == err_beat) ? 2'b10 : 2'b00;
                    if (m_axi_rready) begin
                        beat_i++; beat_total++;
                        if (beat_i == sl_len[0]) begin
                            void'(sl_addr.pop_front()); void'(sl_len.pop_front()); beat_i = 0;
                        end
                    end
                end else if (sl_addr.size() == 0 && spurious) begin
                    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEAD_BEEF; m_axi_rlast = 1'b1; m_axi_rresp = 2'b00;
                end else begin
                    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
                end
                m_axi_arready = ($urandom_range(99) < ar_pct);
                if (m_axi_arvalid && m_axi_arready) begin
                    sl_addr.push_back(m_axi_araddr); sl_len.push_back(int'(m_axi_arlen) + 1);
                    got_ar_addr.push_back(m_axi_araddr); got_ar_len.push_back(int'(m_axi_arlen) + 1);
                end
                #1;
                if (o_fifo_wr_en) got_data.push_back(o_fifo_wr_data);
            end
        end
    end

    task automatic build_model(input logic [31:0] src, w, h, stride);
        logic [31:0] a;
        longint left, l, pg;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
        for (longint r = 0; r < longint'(h); r++) begin
            a = src + 32'(r) * stride;
            left = longint'(w);
            while (left > 0) begin
                pg = (4096 - longint'(a[11:0])) / 4;
                l = left;
                if (l > BL) l = BL;
                if (l > pg) l = pg;
                exp_ar_addr.push_back(a); exp_ar_len.push_back(int'(l));
                for (longint i = 0; i < l; i++) exp_data.push_back(mem_word(a + 32'(4 * i)));
                a = a + 32'(4 * l);
                left -= l;
            end
        end
    endtask

    task automatic start_job(input logic [31:0] src, w, h, stride);
        build_model(src, w, h, stride);
        ar_base = got_ar_addr.size();
        d_base  = got_data.size();
        @(negedge clk);
        i_src_addr = src; i_img_width = w; i_img_height = h; i_img_stride = stride;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        busy1 = o_busy; arv1 = m_axi_arvalid; err1 = o_error;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (o_read_done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        busy_after = o_busy; done_after = o_read_done;
    endtask

    task automatic test_reset;
        reset = 1'b1; i_start = 1'b0; i_src_addr = '0; i_img_width = '0;
        i_img_height = '0; i_img_stride = '0; i_fifo_space = 16'd64;
        repeat (3) @(negedge clk);
        n_checks++; if ({m_axi_arvalid, m_axi_rready, o_fifo_wr_en, o_busy, o_read_done, o_error} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 000000", {m_axi_arvalid, m_axi_rready, o_fifo_wr_en, o_busy, o_read_done, o_error}); end
        n_checks++; if ({m_axi_araddr, m_axi_arlen} !== 40'd0) begin
            n_fail++; $display("FAIL reset_ar: got addr %h len %h required 0", m_axi_araddr, m_axi_arlen); end
        n_checks++; if ({m_axi_arsize, m_axi_arburst} !== 5'b010_01) begin
            n_fail++; $display("FAIL reset_const: got %b required 01001", {m_axi_arsize, m_axi_arburst}); end
        #3 reset = 1'b0;
        spurious = 1'b1;
        repeat (4) begin
            @(negedge clk); #2;
            n_checks++; if ({o_fifo_wr_en, m_axi_rready} !== 2'b00) begin
                n_fail++; $display("FAIL idle_rvalid_ignored: got %b required 00", {o_fifo_wr_en, m_axi_rready}); end
        end
        spurious = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        i_fifo_space = 16'd64;
        start_job(32'h1000, 8, 2, 32'h100);
        n_checks++; if ({busy1, arv1} !== 2'b10) begin
            n_fail++; $display("FAIL basic_plan_cycle: got busy/arvalid %b required 10", {busy1, arv1}); end
        wait_done(cyc);
        n_checks++; if (cyc >= LIMIT) begin n_fail++; $display("FAIL basic_timeout: got %0d cycles required < %0d", cyc, LIMIT); end
        n_checks++; if (got_ar_addr.size() - ar_base !== 2) begin
            n_fail++; $display("FAIL basic_ar_count: got %0d required 2", got_ar_addr.size() - ar_base); end
        n_checks++; if (got_ar_addr[ar_base] !== 32'h1000 || got_ar_len[ar_base] !== 8) begin
            n_fail++; $display("FAIL basic_ar0: got %h/%0d required 1000/8", got_ar_addr[ar_base], got_ar_len[ar_base]); end
        n_checks++; if (got_ar_addr[ar_base+1] !== 32'h1100 || got_ar_len[ar_base+1] !== 8) begin
            n_fail++; $display("FAIL basic_ar1: got %h/%0d required 1100/8", got_ar_addr[ar_base+1], got_ar_len[ar_base+1]); end
        n_checks++; if (got_data.size() - d_base !== 16) begin
            n_fail++; $display("FAIL basic_push_count: got %0d required 16", got_data.size() - d_base); end
        for (int i = 0; i < exp_data.size() && d_base + i < got_data.size(); i++) begin
            n_checks++; if (got_data[d_base+i] !== exp_data[i]) begin
                n_fail++; $display("FAIL basic_data[%0d]: got %h required %h", i, got_data[d_base+i], exp_data[i]); end
        end
        n_checks++; if ({busy_after, done_after, o_error} !== 3'b000) begin
            n_fail++; $display("FAIL basic_end: got busy/done/err %b required 000", {busy_after, done_after, o_error}); end
    endtask

    task automatic test_split_len;
        int cyc;
        logic [31:0] ea[3];
        int el[3];
        ea = '{32'h0, 32'h40, 32'h80}; el = '{16, 16, 8};
        start_job(32'h0, 40, 1, 32'h0);
        wait_done(cyc);
        n_checks++; if (cyc >= LIMIT || got_ar_addr.size() - ar_base !== 3) begin
            n_fail++; $display("FAIL split_ar_count: got %0d (cycles %0d) required 3", got_ar_addr.size() - ar_base, cyc); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (got_ar_addr[ar_base+i] !== ea[i] || got_ar_len[ar_base+i] !== el[i]) begin
                n_fail++; $display("FAIL split_ar%0d: got %h/%0d required %h/%0d", i, got_ar_addr[ar_base+i], got_ar_len[ar_base+i], ea[i], el[i]); end
        end
        n_checks++; if (got_data.size() - d_base !== 40) begin
            n_fail++; $display("FAIL split_push_count: got %0d required 40", got_data.size() - d_base); end
    endtask

    task automatic test_4kb;
        int cyc;
        start_job(32'h0FF0, 16, 1, 32'h0);
        wait_done(cyc);
        n_checks++; if (cyc >= LIMIT || got_ar_addr.size() - ar_base !== 2) begin
            n_fail++; $display("FAIL page_ar_count: got %0d (cycles %0d) required 2", got_ar_addr.size() - ar_base, cyc); end
        n_checks++; if (got_ar_addr[ar_base] !== 32'h0FF0 || got_ar_len[ar_base] !== 4) begin
            n_fail++; $display("FAIL page_ar0: got %h/%0d required 0ff0/4", got_ar_addr[ar_base], got_ar_len[ar_base]); end
        n_checks++; if (got_ar_addr[ar_base+1] !== 32'h1000 || got_ar_len[ar_base+1] !== 12) begin
            n_fail++; $display("FAIL page_ar1: got %h/%0d required 1000/12", got_ar_addr[ar_base+1], got_ar_len[ar_base+1]); end
    endtask

    task automatic test_fifo_space;
        int cyc;
        i_fifo_space = 16'd4;
        start_job(32'h1000, 8, 1, 32'h0);
        repeat (20) @(negedge clk);
        n_checks++; if (got_ar_addr.size() - ar_base !== 0 || m_axi_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL space_hold: got %0d ARs arvalid %b required 0/0", got_ar_addr.size() - ar_base, m_axi_arvalid); end
        i_fifo_space = 16'd8;
        wait_done(cyc);
        n_checks++; if (cyc >= LIMIT || got_ar_addr.size() - ar_base !== 1) begin
            n_fail++; $display("FAIL space_ar_count: got %0d (cycles %0d) required 1", got_ar_addr.size() - ar_base, cyc); end
        n_checks++; if (got_ar_addr[ar_base] !== 32'h1000 || got_ar_len[ar_base] !== 8) begin
            n_fail++; $display("FAIL space_ar0: got %h/%0d required 1000/8", got_ar_addr[ar_base], got_ar_len[ar_base]); end
        i_fifo_space = 16'd64;
    endtask

    task automatic test_errors;
        int cyc;
        err_beat = beat_total + 3;
        start_job(32'h2000, 8, 1, 32'h0);
        wait_done(cyc);
        err_beat = -1;
        n_checks++; if (cyc >= LIMIT || o_error !== 1'b1) begin
            n_fail++; $display("FAIL rresp_error: got %b (cycles %0d) required 1", o_error, cyc); end
        n_checks++; if (got_data.size() - d_base !== 8) begin
            n_fail++; $display("FAIL rresp_push_count: got %0d required 8", got_data.size() - d_base); end
        for (int i = 0; i < exp_data.size() && d_base + i < got_data.size(); i++) begin
            n_checks++; if (got_data[d_base+i] !== exp_data[i]) begin
                n_fail++; $display("FAIL rresp_data[%0d]: got %h required %h", i, got_data[d_base+i], exp_data[i]); end
        end
        start_job(32'h2100, 4, 1, 32'h0);
        n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL error_clear: got %b required 0", err1); end
        wait_done(cyc);
        corrupt_last = 1'b1;
        start_job(32'h2200, 5, 1, 32'h0);
        wait_done(cyc);
        corrupt_last = 1'b0;
        n_checks++; if (cyc >= LIMIT || o_error !== 1'b1) begin
            n_fail++; $display("FAIL rlast_error: got %b (cycles %0d) required 1", o_error, cyc); end
        n_checks++; if (got_data.size() - d_base !== 5) begin
            n_fail++; $display("FAIL rlast_push_count: got %0d required 5", got_data.size() - d_base); end
    endtask

    task automatic test_zero;
        int cyc;
        start_job(32'h1000, 8, 0, 32'h100);
        n_checks++; if ({busy1, arv1, o_read_done} !== 3'b101) begin
            n_fail++; $display("FAIL zero_h_n1: got busy/arvalid/done %b required 101", {busy1, arv1, o_read_done}); end
        wait_done(cyc);
        n_checks++; if (cyc !== 0 || {busy_after, done_after} !== 2'b00) begin
            n_fail++; $display("FAIL zero_h_end: got cycles %0d busy/done %b required 0/00", cyc, {busy_after, done_after}); end
        start_job(32'h1000, 0, 3, 32'h100);
        wait_done(cyc);
        n_checks++; if (cyc !== 0 || got_ar_addr.size() - ar_base !== 0) begin
            n_fail++; $display("FAIL zero_w: got cycles %0d ARs %0d required 0/0", cyc, got_ar_addr.size() - ar_base); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        start_job(32'h3000, 16, 2, 32'h40);
        cyc = 0;
        while (!(m_axi_rready === 1'b1 && o_fifo_wr_en === 1'b1) && cyc < LIMIT) begin
            @(negedge clk); #2; cyc++;
        end
        n_checks++; if (cyc >= LIMIT) begin n_fail++; $display("FAIL midreset_reach_rdat: got %0d cycles required < %0d", cyc, LIMIT); end
        reset = 1'b1;
        #1;
        n_checks++; if ({m_axi_arvalid, m_axi_rready, o_fifo_wr_en, o_busy, o_read_done, o_error} !== 6'b0) begin
            n_fail++; $display("FAIL midreset_ctrl: got %b required 000000", {m_axi_arvalid, m_axi_rready, o_fifo_wr_en, o_busy, o_read_done, o_error}); end
        n_checks++; if ({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {40'd0, 5'b010_01}) begin
            n_fail++; $display("FAIL midreset_ar: got %h/%h/%b/%b required 0/0/010/01", m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst); end
        @(negedge clk);
        @(negedge clk); #3;
        reset = 1'b0;
    endtask

    task automatic test_random;
        int cyc;
        logic [31:0] src, w, h, stride;
        for (int j = 0; j < 8; j++) begin
            ar_pct = $urandom_range(20, 100);
            rv_pct = $urandom_range(20, 100);
            i_fifo_space = 16'($urandom_range(16, 300));
            src    = {20'd0, 10'($urandom), 2'b00} + 32'h7000;
            w      = $urandom_range(1, 40);
            h      = $urandom_range(1, 4);
            stride = {18'd0, 12'($urandom), 2'b00};
            start_job(src, w, h, stride);
            wait_done(cyc);
            n_checks++; if (cyc >= LIMIT) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d cycles required < %0d", j, cyc, LIMIT); end
            n_checks++; if (got_ar_addr.size() - ar_base !== exp_ar_addr.size()) begin
                n_fail++; $display("FAIL rand%0d_ar_count: got %0d required %0d", j, got_ar_addr.size() - ar_base, exp_ar_addr.size()); end
            for (int i = 0; i < exp_ar_addr.size() && ar_base + i < got_ar_addr.size(); i++) begin
                n_checks++; if (got_ar_addr[ar_base+i] !== exp_ar_addr[i] || got_ar_len[ar_base+i] !== exp_ar_len[i]) begin
                    n_fail++; $display("FAIL rand%0d_ar%0d: got %h/%0d required %h/%0d", j, i,
                                       got_ar_addr[ar_base+i], got_ar_len[ar_base+i], exp_ar_addr[i], exp_ar_len[i]); end
            end
            n_checks++; if (got_data.size() - d_base !== exp_data.size()) begin
                n_fail++; $display("FAIL rand%0d_push_count: got %0d required %0d", j, got_data.size() - d_base, exp_data.size()); end
            for (int i = 0; i < exp_data.size() && d_base + i < got_data.size(); i++) begin
                n_checks++; if (got_data[d_base+i] !== exp_data[i]) begin
                    n_fail++; $display("FAIL rand%0d_data%0d: got %h required %h", j, i, got_data[d_base+i], exp_data[i]); end
            end
            n_checks++; if ({o_error, busy_after} !== 2'b00) begin
                n_fail++; $display("FAIL rand%0d_end: got err/busy %b required 00", j, {o_error, busy_after}); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_split_len();
        test_4kb();
        test_fifo_space();
        test_errors();
        test_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
